// File: rtl/vx_raster_dcr_bank_if.sv
// Host-side DCR bus for the raster DCR bank: write strobe, read-back
// request/response and the commit handshake.
interface vx_raster_dcr_bank_if #(
  parameter int unsigned NUM_SLOTS = 1,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned ADDR_BITS = 12
);
  logic                 dcr_write_valid;
  logic [ADDR_BITS-1:0] dcr_write_addr;
  logic [DATA_BITS-1:0] dcr_write_data;
  logic                 dcr_read_valid;
  logic [ADDR_BITS-1:0] dcr_read_addr;
  logic                 dcr_read_bank;
  logic                 dcr_rsp_valid;
  logic [DATA_BITS-1:0] dcr_rsp_data;
  logic                 commit_valid;
  logic [NUM_SLOTS-1:0] commit_mask;
  logic                 commit_ready;

  modport master (
    output dcr_write_valid, dcr_write_addr, dcr_write_data,
    output dcr_read_valid, dcr_read_addr, dcr_read_bank,
    input  dcr_rsp_valid, dcr_rsp_data,
    output commit_valid, commit_mask,
    input  commit_ready
  );

  modport slave (
    input  dcr_write_valid, dcr_write_addr, dcr_write_data,
    input  dcr_read_valid, dcr_read_addr, dcr_read_bank,
    output dcr_rsp_valid, dcr_rsp_data,
    input  commit_valid, commit_mask,
    output commit_ready
  );
endinterface

// File: rtl/vx_raster_dcr_bank.sv
// Double-buffered raster DCR bank: per-slot shadow registers written by the
// host, promoted to the active registers by a commit while the slot is idle.
module vx_raster_dcr_bank #(
  parameter int unsigned          NUM_SLOTS = 1,
  parameter int unsigned          DATA_BITS = 32,
  parameter int unsigned          TILE_BITS = 16,
  parameter int unsigned          ADDR_BITS = 12,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = 12'h100
) (
  input  logic                                              clk,
  input  logic                                              reset,
  vx_raster_dcr_bank_if.slave                               bus,
  input  logic [NUM_SLOTS-1:0]                              slot_busy,
  output logic [NUM_SLOTS-1:0]                              dirty,
  output logic [NUM_SLOTS*(4*DATA_BITS+4*TILE_BITS)-1:0]    dcrs_active
);
  localparam int unsigned          SLOT_BITS = 4*DATA_BITS + 4*TILE_BITS;
  localparam int unsigned          SLOT_AW   = ADDR_BITS - 3;
  localparam logic [ADDR_BITS:0]   SPAN      = (ADDR_BITS+1)'(8*(NUM_SLOTS+1));
  localparam logic [SLOT_AW-1:0]   BCAST     = SLOT_AW'(NUM_SLOTS);

  // Fields 0..3 are the DATA_BITS-wide pidx/pbuf group, 4..7 the tile group.
  logic [DATA_BITS-1:0] sh_data [NUM_SLOTS][4];
  logic [TILE_BITS-1:0] sh_tile [NUM_SLOTS][4];
  logic [DATA_BITS-1:0] ac_data [NUM_SLOTS][4];
  logic [TILE_BITS-1:0] ac_tile [NUM_SLOTS][4];

  // Offsets are one bit wider so addresses below BASE_ADDR wrap high and
  // fail the single range compare.
  logic [ADDR_BITS:0]   wr_off, rd_off;
  logic                 wr_in, rd_in;
  logic [SLOT_AW-1:0]   wr_slot, rd_slot;
  logic [2:0]           wr_field, rd_field;
  logic [NUM_SLOTS-1:0] wr_hit;
  logic                 commit_fire;
  logic [DATA_BITS-1:0] rd_value;

  assign wr_off   = {1'b0, bus.dcr_write_addr} - {1'b0, BASE_ADDR};
  assign wr_in    = wr_off < SPAN;
  assign wr_slot  = wr_off[ADDR_BITS-1:3];
  assign wr_field = wr_off[2:0];
  assign rd_off   = {1'b0, bus.dcr_read_addr} - {1'b0, BASE_ADDR};
  assign rd_in    = rd_off < SPAN;
  assign rd_slot  = rd_off[ADDR_BITS-1:3];
  assign rd_field = rd_off[2:0];

  assign bus.commit_ready = ~|(bus.commit_mask & slot_busy);
  assign commit_fire      = bus.commit_valid & bus.commit_ready;

  // Per-slot write select, including the broadcast window.
  always_comb begin
    wr_hit = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      wr_hit[s] = bus.dcr_write_valid && wr_in &&
                  ((wr_slot == SLOT_AW'(s)) || (wr_slot == BCAST));
    end
  end

  // Bank update: commit copies the pre-write shadow; a same-cycle write is
  // ordered after the commit so its dirty set overrides the commit's clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        for (int unsigned f = 0; f < 4; f++) begin
          sh_data[s][f] <= '0;
          sh_tile[s][f] <= '0;
          ac_data[s][f] <= '0;
          ac_tile[s][f] <= '0;
        end
      end
      dirty <= '0;
    end else begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (commit_fire && bus.commit_mask[s]) begin
          ac_data[s] <= sh_data[s];
          ac_tile[s] <= sh_tile[s];
          dirty[s]   <= 1'b0;
        end
        if (wr_hit[s]) begin
          dirty[s] <= 1'b1;
          if (!wr_field[2]) sh_data[s][wr_field[1:0]] <= bus.dcr_write_data;
          else              sh_tile[s][wr_field[1:0]] <= bus.dcr_write_data[TILE_BITS-1:0];
        end
      end
    end
  end

  // Read-back mux; broadcast and out-of-range addresses match no slot.
  always_comb begin
    rd_value = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (rd_in && (rd_slot == SLOT_AW'(s))) begin
        if (!rd_field[2])
          rd_value = bus.dcr_read_bank ? ac_data[s][rd_field[1:0]] : sh_data[s][rd_field[1:0]];
        else
          rd_value = DATA_BITS'(bus.dcr_read_bank ? ac_tile[s][rd_field[1:0]]
                                                  : sh_tile[s][rd_field[1:0]]);
      end
    end
  end

  // Registered read-back response.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dcr_rsp_valid <= 1'b0;
      bus.dcr_rsp_data  <= '0;
    end else begin
      bus.dcr_rsp_valid <= bus.dcr_read_valid;
      if (bus.dcr_read_valid) bus.dcr_rsp_data <= rd_value;
    end
  end

  // Active banks packed per slot, pidx_addr at the MSBs.
  always_comb begin
    dcrs_active = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      dcrs_active[s*SLOT_BITS +: SLOT_BITS] = {ac_data[s][0], ac_data[s][1], ac_data[s][2], ac_data[s][3],
                                               ac_tile[s][0], ac_tile[s][1], ac_tile[s][2], ac_tile[s][3]};
    end
  end
endmodule

// File: tb/tb_vx_raster_dcr_bank.sv
// Self-checking bench for vx_raster_dcr_bank with two slots at base 0x100.
module tb_vx_raster_dcr_bank;
  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   slot_busy;
  logic [1:0]   dirty;
  logic [383:0] dcrs_active;

  int checks = 0;
  int passed = 0;

  vx_raster_dcr_bank_if #(.NUM_SLOTS(2), .DATA_BITS(32), .ADDR_BITS(12)) bus ();

  vx_raster_dcr_bank #(
    .NUM_SLOTS(2), .DATA_BITS(32), .TILE_BITS(16), .ADDR_BITS(12), .BASE_ADDR(12'h100)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .slot_busy(slot_busy), .dirty(dirty), .dcrs_active(dcrs_active)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays indexed by [slot][field].
  logic [31:0] m_sh [2][8];
  logic [31:0] m_ac [2][8];
  logic [1:0]  m_dirty;
  logic        m_rv;
  logic [31:0] m_rd;

  function automatic logic [31:0] m_read(input logic [11:0] a, input logic bank);
    int off = int'(a) - 256;
    if (off < 0 || off >= 24 || off / 8 >= 2) return 32'h0;
    return bank ? m_ac[off/8][off%8] : m_sh[off/8][off%8];
  endfunction

  function automatic logic [383:0] m_pack();
    logic [383:0] p = '0;
    for (int s = 0; s < 2; s++)
      for (int f = 0; f < 8; f++)
        if (f < 4) p[s*192 + 64 + (3-f)*32 +: 32] = m_ac[s][f];
        else       p[s*192 + (7-f)*16 +: 16]      = m_ac[s][f][15:0];
    return p;
  endfunction

  // Advance one clock, updating the model from the inputs applied this cycle.
  task automatic step();
    logic [31:0] nsh [2][8];
    logic [31:0] nac [2][8];
    logic [1:0]  nd;
    logic        nrv;
    logic [31:0] nrd;
    int          off;
    nsh = m_sh; nac = m_ac; nd = m_dirty; nrv = m_rv; nrd = m_rd;
    if (reset) begin
      for (int s = 0; s < 2; s++)
        for (int f = 0; f < 8; f++) begin nsh[s][f] = 0; nac[s][f] = 0; end
      nd = 0; nrv = 0; nrd = 0;
    end else begin
      nrv = bus.dcr_read_valid;
      if (bus.dcr_read_valid) nrd = m_read(bus.dcr_read_addr, bus.dcr_read_bank);
      if (bus.commit_valid && ((bus.commit_mask & slot_busy) == 2'b00))
        for (int s = 0; s < 2; s++)
          if (bus.commit_mask[s]) begin nac[s] = m_sh[s]; nd[s] = 1'b0; end
      off = int'(bus.dcr_write_addr) - 256;
      if (bus.dcr_write_valid && off >= 0 && off < 24)
        for (int s = 0; s < 2; s++)
          if (off / 8 == s || off / 8 == 2) begin
            nsh[s][off%8] = (off % 8 >= 4) ? (bus.dcr_write_data & 32'h0000_FFFF) : bus.dcr_write_data;
            nd[s] = 1'b1;
          end
    end
    @(posedge clk);
    #1;
    m_sh = nsh; m_ac = nac; m_dirty = nd; m_rv = nrv; m_rd = nrd;
  endtask

  task automatic idle();
    reset = 1'b0; slot_busy = 2'b00;
    bus.dcr_write_valid = 1'b0; bus.dcr_write_addr = '0; bus.dcr_write_data = '0;
    bus.dcr_read_valid = 1'b0; bus.dcr_read_addr = '0; bus.dcr_read_bank = 1'b0;
    bus.commit_valid = 1'b0; bus.commit_mask = 2'b00;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++; if (dcrs_active !== '0) $display("FAIL reset_active got=%h exp=0", dcrs_active); else passed++;
    checks++; if (dirty !== 2'b00) $display("FAIL reset_dirty got=%b exp=00", dirty); else passed++;
    checks++; if (bus.dcr_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", bus.dcr_rsp_valid); else passed++;
    checks++; if (bus.dcr_rsp_data !== 32'h0) $display("FAIL reset_rsp_data got=%h exp=0", bus.dcr_rsp_data); else passed++;
  endtask

  task automatic test_write_commit();
    idle();
    bus.dcr_write_valid = 1'b1; bus.dcr_write_addr = 12'h100; bus.dcr_write_data = 32'hDEADBEEF;
    step();
    idle();
    checks++; if (dirty !== 2'b01) $display("FAIL wc_dirty_after_write got=%b exp=01", dirty); else passed++;
    checks++; if (dcrs_active !== '0) $display("FAIL wc_active_before_commit got=%h exp=0", dcrs_active); else passed++;
    bus.commit_valid = 1'b1; bus.commit_mask = 2'b01;
    step();
    idle();
    checks++; if (dirty !== 2'b00) $display("FAIL wc_dirty_after_commit got=%b exp=00", dirty); else passed++;
    checks++; if (dcrs_active[191:160] !== 32'hDEADBEEF) $display("FAIL wc_slot0_pidx got=%h exp=deadbeef", dcrs_active[191:160]); else passed++;
    checks++; if (dcrs_active[383:192] !== '0) $display("FAIL wc_slot1_active got=%h exp=0", dcrs_active[383:192]); else passed++;
  endtask

  task automatic test_broadcast();
    idle();
    bus.dcr_write_valid = 1'b1; bus.dcr_write_addr = 12'h116; bus.dcr_write_data = 32'h0012_0040;
    step();
    idle();
    checks++; if (dirty !== 2'b11) $display("FAIL bc_dirty got=%b exp=11", dirty); else passed++;
    bus.dcr_read_valid = 1'b1; bus.dcr_read_addr = 12'h106; bus.dcr_read_bank = 1'b0;
    step();
    checks++; if (bus.dcr_rsp_data !== 32'h40 || bus.dcr_rsp_valid !== 1'b1) $display("FAIL bc_shadow_slot0 got=%h/%b exp=40/1", bus.dcr_rsp_data, bus.dcr_rsp_valid); else passed++;
    bus.dcr_read_addr = 12'h10E;
    step();
    checks++; if (bus.dcr_rsp_data !== 32'h40) $display("FAIL bc_shadow_slot1 got=%h exp=40", bus.dcr_rsp_data); else passed++;
    bus.dcr_read_addr = 12'h106; bus.dcr_read_bank = 1'b1;
    step();
    checks++; if (bus.dcr_rsp_data !== 32'h0) $display("FAIL bc_active_slot0 got=%h exp=0", bus.dcr_rsp_data); else passed++;
    idle();
  endtask

  task automatic test_busy();
    idle();
    slot_busy = 2'b10; bus.commit_valid = 1'b1; bus.commit_mask = 2'b11;
    #1;
    checks++; if (bus.commit_ready !== 1'b0) $display("FAIL busy_ready_11 got=%b exp=0", bus.commit_ready); else passed++;
    step();
    checks++; if (dcrs_active[31:16] !== 16'h0 || dirty !== 2'b11) $display("FAIL busy_no_commit got=%h/%b exp=0/11", dcrs_active[31:16], dirty); else passed++;
    bus.commit_mask = 2'b01;
    #1;
    checks++; if (bus.commit_ready !== 1'b1) $display("FAIL busy_ready_01 got=%b exp=1", bus.commit_ready); else passed++;
    step();
    idle();
    checks++; if (dcrs_active[31:16] !== 16'h40) $display("FAIL busy_slot0_tw got=%h exp=0040", dcrs_active[31:16]); else passed++;
    checks++; if (dcrs_active[223:208] !== 16'h0) $display("FAIL busy_slot1_tw got=%h exp=0", dcrs_active[223:208]); else passed++;
    checks++; if (dirty !== 2'b10) $display("FAIL busy_dirty got=%b exp=10", dirty); else passed++;
  endtask

  task automatic test_write_and_commit_same_cycle();
    idle();
    bus.dcr_write_valid = 1'b1; bus.dcr_write_addr = 12'h108; bus.dcr_write_data = 32'd3;
    step();
    bus.dcr_write_data = 32'd5; bus.commit_valid = 1'b1; bus.commit_mask = 2'b10;
    step();
    idle();
    checks++; if (dcrs_active[383:352] !== 32'd3) $display("FAIL same_active got=%h exp=3", dcrs_active[383:352]); else passed++;
    checks++; if (dirty[1] !== 1'b1) $display("FAIL same_dirty got=%b exp=1", dirty[1]); else passed++;
    bus.dcr_read_valid = 1'b1; bus.dcr_read_addr = 12'h108; bus.dcr_read_bank = 1'b0;
    step();
    idle();
    checks++; if (bus.dcr_rsp_data !== 32'd5) $display("FAIL same_shadow got=%h exp=5", bus.dcr_rsp_data); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] addrs [3] = '{12'h100, 12'h0FF, 12'h118};
    logic        banks [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] exps  [3] = '{32'hDEADBEEF, 32'h0, 32'h0};
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.dcr_read_valid = 1'b1; bus.dcr_read_addr = addrs[i]; bus.dcr_read_bank = banks[i];
      step();
      checks++;
      if (bus.dcr_rsp_valid !== 1'b1 || bus.dcr_rsp_data !== exps[i])
        $display("FAIL b2b_read%0d got=%h/%b exp=%h/1", i, bus.dcr_rsp_data, bus.dcr_rsp_valid, exps[i]);
      else passed++;
    end
    idle();
    step();
    checks++; if (bus.dcr_rsp_valid !== 1'b0) $display("FAIL b2b_pulse got=%b exp=0", bus.dcr_rsp_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    idle();
    reset = 1'b1;
    bus.dcr_write_valid = 1'b1; bus.dcr_write_addr = 12'h101; bus.dcr_write_data = 32'h1234;
    bus.commit_valid = 1'b1; bus.commit_mask = 2'b11;
    bus.dcr_read_valid = 1'b1; bus.dcr_read_addr = 12'h100;
    step();
    idle();
    checks++; if (dcrs_active !== '0 || dirty !== 2'b00) $display("FAIL rmid_state got=%h/%b exp=0/00", dcrs_active, dirty); else passed++;
    checks++; if (bus.dcr_rsp_valid !== 1'b0 || bus.dcr_rsp_data !== 32'h0) $display("FAIL rmid_rsp got=%h/%b exp=0/0", bus.dcr_rsp_data, bus.dcr_rsp_valid); else passed++;
    bus.dcr_read_valid = 1'b1; bus.dcr_read_addr = 12'h100;
    step();
    idle();
    checks++; if (bus.dcr_rsp_valid !== 1'b1 || bus.dcr_rsp_data !== 32'h0) $display("FAIL rmid_read got=%h/%b exp=0/1", bus.dcr_rsp_data, bus.dcr_rsp_valid); else passed++;
  endtask

  task automatic test_random();
    logic exp_ready;
    idle();
    for (int i = 0; i < 400; i++) begin
      bus.dcr_write_valid = 1'($urandom);
      bus.dcr_write_addr  = 12'h0F8 + 12'($urandom_range(0, 40));
      bus.dcr_write_data  = $urandom;
      bus.dcr_read_valid  = 1'($urandom);
      bus.dcr_read_addr   = 12'h0F8 + 12'($urandom_range(0, 40));
      bus.dcr_read_bank   = 1'($urandom);
      bus.commit_valid    = ($urandom_range(0, 3) == 0);
      bus.commit_mask     = 2'($urandom);
      slot_busy           = 2'($urandom);
      #1;
      exp_ready = ((bus.commit_mask & slot_busy) == 2'b00);
      checks++; if (bus.commit_ready !== exp_ready) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, bus.commit_ready, exp_ready); else passed++;
      step();
      checks++; if (dcrs_active !== m_pack()) $display("FAIL rnd_active cyc=%0d got=%h exp=%h", i, dcrs_active, m_pack()); else passed++;
      checks++; if (dirty !== m_dirty) $display("FAIL rnd_dirty cyc=%0d got=%b exp=%b", i, dirty, m_dirty); else passed++;
      checks++; if (bus.dcr_rsp_valid !== m_rv) $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", i, bus.dcr_rsp_valid, m_rv); else passed++;
      if (m_rv) begin
        checks++; if (bus.dcr_rsp_data !== m_rd) $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", i, bus.dcr_rsp_data, m_rd); else passed++;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_commit();
    test_broadcast();
    test_busy();
    test_write_and_commit_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/vx_raster_dcr_bank.md
# VX_raster_dcr_bank

Parametrised, double-buffered DCR register bank for the raster stage. It captures device-configuration writes for `NUM_SLOTS` raster units into per-slot shadow copies of the `raster_dcrs_t` field set: pidx_addr, pidx_size, pbuf_addr, pbuf_stride, tile_left, tile_top, tile_width and tile_height. A commit handshake atomically promotes the shadow copies to the active copies that drive the raster units, and only while the targeted units are idle. A registered read-back port exposes both banks to the host path.

## Interface
- `NUM_SLOTS`, 1: number of raster units (slots); 1..16.
- `DATA_BITS`, 32: width of the pidx/pbuf fields and of DCR data.
- `TILE_BITS`, 16: width of the tile_* fields; must be ≤ `DATA_BITS`.
- `ADDR_BITS`, 12: DCR address width.
- `BASE_ADDR`, 12'h100: first DCR address of the bank.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `dcr_write_valid`, in, 1: DCR write strobe. Always accepted; there is no backpressure.
- `dcr_write_addr`, in, `ADDR_BITS`: DCR write address.
- `dcr_write_data`, in, `DATA_BITS`: DCR write data.
- `dcr_read_valid`, in, 1: read-back request.
- `dcr_read_addr`, in, `ADDR_BITS`: read-back address.
- `dcr_read_bank`, in, 1: 0 reads the shadow bank, 1 reads the active bank.
- `dcr_rsp_valid`, out, 1: read-back response strobe.
- `dcr_rsp_data`, out, `DATA_BITS`: read-back data.
- `commit_valid`, in, 1: commit request.
- `commit_mask`, in, `NUM_SLOTS`: slots to commit.
- `commit_ready`, out, 1: commit can be accepted this cycle.
- `slot_busy`, in, `NUM_SLOTS`: the raster unit in each slot is processing work.
- `dirty`, out, `NUM_SLOTS`: the slot's shadow bank differs from its active bank by at least one write.
- `dcrs_active`, out, `NUM_SLOTS*(4*DATA_BITS+4*TILE_BITS)`: active banks. Slot 0 occupies the LSBs. Each slot uses the packed `raster_dcrs_t` layout, with pidx_addr at the MSBs and tile_height at the LSBs.

## Operation
- Address decode:
  - off = addr − `BASE_ADDR`; field = off[2:0] in struct order (0 = pidx_addr … 7 = tile_height); slot = off[ADDR_BITS-1:3].
  - Slot values 0..`NUM_SLOTS`−1 are per-slot addresses.
  - Slot value `NUM_SLOTS` is the broadcast window.
  - Addresses below `BASE_ADDR` or at/above `BASE_ADDR`+8*(`NUM_SLOTS`+1) are out of range.
- Write:
  - A per-slot address updates that slot's shadow field. A broadcast address updates the field in every slot.
  - Every updated slot has its `dirty` bit set.
  - Out-of-range writes are ignored and change no state.
  - tile_* fields keep data[`TILE_BITS`-1:0]; higher data bits are discarded.
- Commit:
  - commit_ready = no slot in `commit_mask` has `slot_busy` set.
  - On the cycle where commit_valid and commit_ready are both high, active ← shadow and dirty ← 0 for every masked slot.
  - Unmasked slots are untouched.
  - commit_mask = 0 is a legal no-op.
- Simultaneous write and commit on the same slot in the same cycle:
  - active takes the shadow value from before the write.
  - The shadow bank takes the new write.
  - dirty ends the cycle at 1 (the write wins over the commit's clear).
- Read-back:
  - The selected bank's field is returned, zero-extended to `DATA_BITS`.
  - Reads of the broadcast window or of out-of-range addresses return 0.
  - A read of the shadow bank in the same cycle as a write to that field returns the old value.
- Reset: shadow, active, dirty, dcr_rsp_valid and dcr_rsp_data all go to 0. A reset asserted in the middle of any operation discards the pending write, commit and read in that cycle.

## Timing
- Write: the shadow bank and `dirty` update at the clock edge that samples the write; both are visible the next cycle.
- Commit: `dcrs_active` changes the cycle after the handshake. commit_ready is combinational from `slot_busy` and `commit_mask`.
- A slot that becomes busy in the same cycle as a commit handshake still commits, because ready was evaluated with the current `slot_busy`.
- Read-back: `dcr_rsp_valid` and `dcr_rsp_data` are registered, one cycle after `dcr_read_valid`. Back-to-back reads give one response per cycle. `dcr_rsp_valid` is a single-cycle pulse per request.
- There is no internal state machine beyond the bank registers and the response register. Throughput is one write, one read and one commit per cycle.

## Test plan
- Reset, then with `NUM_SLOTS`=2, `BASE_ADDR`=0x100: write 0x100 ← 0xDEADBEEF and commit with mask 01.
  - The slot 0 pidx_addr active field reads 0xDEADBEEF.
  - dirty goes 01 after the write and 00 after the commit.
  - Slot 1's active bank is unchanged (0).
- Write broadcast address 0x116 ← 0x0012_0040 (tile_width).
  - The shadow tile_width of both slots reads 0x0040.
  - dirty = 11.
  - Active-bank reads still return 0.
- With slot_busy = 10: commit_valid with mask 11 gives commit_ready = 0 and no change; mask 01 gives ready = 1 and only slot 0 commits.
- Write 0x108 ← 5 in the same cycle as a commit of slot 1 (shadow 3).
  - Slot 1 active pidx_addr = 3, shadow = 5, dirty[1] = 1.
- Read-back of shadow addresses 0x100 and 0x0FF, then active 0x118.
  - Responses arrive one cycle after each request: data 0xDEADBEEF, 0, 0.
- Assert reset after writes and commits. All outputs are 0 on the next cycle, and a read of 0x100 returns 0.
